// File: rtl/dm_banked_if.sv
// dm_banked_if: request/response bus of the banked data memory.
//   master: drives req, we, size, sext, addr, wdata; observes ready, done, rdata, err
//   slave : the memory side of the same signals
//   ADDR_W: byte-address width, must match the attached dm_banked.
interface dm_banked_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/dm_banked.sv
// dm_banked: handshaked, big-endian, four-byte-lane data memory for the MEM stage.
// Byte/half/word loads (sign or zero extended) and stores, LAT wait states per access.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (control and response registers only;
//           memory contents are never reset)
//   bus   - dm_banked_if.slave: req/we/size/sext/addr/wdata in, ready/done/rdata/err out
// Parameters: ADDR_W (byte-address width), LAT (wait states, 0..15).
// Optional feature: define DM_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses and size=11 with err=1 (no write, rdata=0). Without it, err is 0,
// the low address bits are forced aligned and size=11 acts as a word access.
module dm_banked #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_banked_if.slave  bus
);
    localparam int WORDS = 1 << (ADDR_W - 2);
    localparam logic [3:0] CNT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        accept;

    logic              we_p0;
    logic              sext_p0;
    logic [1:0]        size_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       wdata_p0;

    logic [1:0]        eff_size;
    logic [1:0]        lo;
    logic              bad;
    logic [3:0]        lane_en;
    logic [31:0]       wword;
    logic [31:0]       rword;
    logic [ADDR_W-3:0] widx;

    logic [31:0] rdata_q;
    logic        err_q;

    // One packed word per entry; byte [3] is lane 0 (bits 31:24, addr[1:0]=00).
    logic [3:0][7:0] mem [WORDS];

    // Extract and extend a load result from the addressed word.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] a_lo, input logic sx);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (a_lo)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = a_lo[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   load_ext = sx ? 32'(b) : {24'd0, b};
            2'b01:   load_ext = sx ? 32'(h) : {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Control FSM: ready in IDLE and RESP so RESP overlaps the next acceptance.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (LAT > 0) begin
                        state_nx = S_WAIT;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        state_nx = S_ACCESS;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = S_ACCESS;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_ACCESS: state_nx = S_RESP;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            // Response registers are zero except in the cycle after ACCESS.
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            if (state == S_ACCESS) begin
                err_q <= bad;
                if (!we_p0 && !bad) begin
                    rdata_q <= load_ext(rword, eff_size, lo, sext_p0);
                end
            end
        end
    end

    // Stage p0: request latched at acceptance, held through WAIT/ACCESS.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.we;
            sext_p0  <= bus.sext;
            size_p0  <= bus.size;
            addr_p0  <= bus.addr;
            wdata_p0 <= bus.wdata;
        end
    end

`ifdef DM_MISALIGN_TRAP_EN
    assign eff_size = size_p0;
    assign lo       = addr_p0[1:0];
    assign bad      = (size_p0 == 2'b11) ||
                      (size_p0 == 2'b01 && addr_p0[0]) ||
                      (size_p0 == 2'b10 && addr_p0[1:0] != 2'b00);
`else
    assign eff_size = (size_p0 == 2'b11) ? 2'b10 : size_p0;
    assign lo       = (eff_size == 2'b10) ? 2'b00 :
                      (eff_size == 2'b01) ? {addr_p0[1], 1'b0} : addr_p0[1:0];
    assign bad      = 1'b0;
`endif

    assign widx  = addr_p0[ADDR_W-1:2];
    assign rword = mem[widx];

    // Right-aligned store data is replicated so every enabled lane sees its byte.
    always_comb begin
        lane_en = 4'b1111;
        wword   = wdata_p0;
        case (eff_size)
            2'b00: begin
                lane_en = 4'b1000 >> lo;
                wword   = {4{wdata_p0[7:0]}};
            end
            2'b01: begin
                lane_en = lo[1] ? 4'b0011 : 4'b1100;
                wword   = {2{wdata_p0[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wword   = wdata_p0;
            end
        endcase
    end

    // Stage p1: all enabled lanes are written together on the ACCESS edge.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_ACCESS && we_p0 && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[widx][i] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready = (state == S_IDLE) || (state == S_RESP);
    assign bus.done  = (state == S_RESP);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_dm_banked.sv
// tb_dm_banked: scoreboard bench for dm_banked with three instances (LAT=0,1,3)
// sharing stimulus; only the selected instance sees req.
module tb_dm_banked;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        req = 1'b0, we = 1'b0, sext = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    int          sel = 1;

    dm_banked_if #(.ADDR_W(10)) bus_l0();
    dm_banked_if #(.ADDR_W(10)) bus_l1();
    dm_banked_if #(.ADDR_W(10)) bus_l3();

    assign bus_l0.req = req && (sel == 0);
    assign bus_l1.req = req && (sel == 1);
    assign bus_l3.req = req && (sel == 2);
    assign bus_l0.we = we;    assign bus_l1.we = we;    assign bus_l3.we = we;
    assign bus_l0.size = size; assign bus_l1.size = size; assign bus_l3.size = size;
    assign bus_l0.sext = sext; assign bus_l1.sext = sext; assign bus_l3.sext = sext;
    assign bus_l0.addr = addr; assign bus_l1.addr = addr; assign bus_l3.addr = addr;
    assign bus_l0.wdata = wdata; assign bus_l1.wdata = wdata; assign bus_l3.wdata = wdata;

    dm_banked #(.ADDR_W(10), .LAT(0)) u_dut_l0 (.clk(clk), .rst_n(rst_n), .bus(bus_l0));
    dm_banked #(.ADDR_W(10), .LAT(1)) u_dut    (.clk(clk), .rst_n(rst_n), .bus(bus_l1));
    dm_banked #(.ADDR_W(10), .LAT(3)) u_dut_l3 (.clk(clk), .rst_n(rst_n), .bus(bus_l3));

    logic        cur_ready, cur_done, cur_err;
    logic [31:0] cur_rdata;
    always_comb begin
        cur_ready = bus_l1.ready;
        cur_done  = bus_l1.done;
        cur_err   = bus_l1.err;
        cur_rdata = bus_l1.rdata;
        case (sel)
            0: begin
                cur_ready = bus_l0.ready; cur_done = bus_l0.done;
                cur_err   = bus_l0.err;   cur_rdata = bus_l0.rdata;
            end
            2: begin
                cur_ready = bus_l3.ready; cur_done = bus_l3.done;
                cur_err   = bus_l3.err;   cur_rdata = bus_l3.rdata;
            end
            default: ;
        endcase
    end

    function automatic int lat_cur();
        case (sel)
            0:       return 0;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Response monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cur_done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rdata", cur_rdata, mon_e.rdata);
                    chk("err", {31'd0, cur_err}, {31'd0, mon_e.err});
                    chk("latency", 32'(cyc), 32'(mon_e.due));
                end
            end else begin
                if (cur_rdata != 32'd0) chk("rdata_idle", cur_rdata, 32'd0);
                if (cur_err) chk("err_idle", 32'd1, 32'd0);
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    chk("done_timeout", 32'(cyc), 32'(sb[0].due));
                    void'(sb.pop_front());
                end
            end
        end
    end

    int acc_cyc = 0;

    // Drive one request at a negedge where ready is high; returns on the accept edge.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [9:0] a, input logic [31:0] d,
                          input logic [31:0] exp_r, input logic exp_e);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!cur_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!cur_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        we = w; size = sz; sext = sx; addr = a; wdata = d; req = 1'b1;
        e.rdata = exp_r;
        e.err   = exp_e;
        e.due   = cyc + lat_cur() + 2;
        sb.push_back(e);
        acc_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic drop_req();
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            chk("drain", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic xfer(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [9:0] a, input logic [31:0] d,
                        input logic [31:0] exp_r, input logic exp_e);
        access(w, sz, sx, a, d, exp_r, exp_e);
        drop_req();
        drain();
    endtask

    logic [31:0] v40;
    logic [31:0] b2b_st [4] = '{32'hF00DF00D, 32'h01234567, 32'h89ABCDEF, 32'h7F00FF80};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int prev;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cur_ready}, 32'd1);
        chk("rst_done", {31'd0, cur_done}, 32'd0);
        chk("rst_rdata", cur_rdata, 32'd0);
        chk("rst_err", {31'd0, cur_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LAT=1 word store and readback
        sel = 1;
        xfer(1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344, 32'd0, 1'b0);
        xfer(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h11223344, 1'b0);
        xfer(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 32'h00000044, 1'b0);
        xfer(1'b0, 2'b00, 1'b1, 10'h010, 32'h0, 32'h00000011, 1'b0);
        xfer(1'b0, 2'b00, 1'b1, 10'h012, 32'h0, 32'h00000033, 1'b0);

        // Byte store, signed/unsigned byte loads
        xfer(1'b1, 2'b10, 1'b0, 10'h020, 32'hA1B2C3D4, 32'd0, 1'b0);
        xfer(1'b1, 2'b00, 1'b0, 10'h021, 32'h5A5A5A80, 32'd0, 1'b0);
        xfer(1'b0, 2'b00, 1'b1, 10'h021, 32'h0, 32'hFFFFFF80, 1'b0);
        xfer(1'b0, 2'b00, 1'b0, 10'h021, 32'h0, 32'h00000080, 1'b0);
        xfer(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'hA180C3D4, 1'b0);

        // Halfword store into the low half of word 0x030
        xfer(1'b1, 2'b10, 1'b0, 10'h030, 32'h55667788, 32'd0, 1'b0);
        xfer(1'b1, 2'b01, 1'b0, 10'h032, 32'h1234BEEF, 32'd0, 1'b0);
        xfer(1'b0, 2'b10, 1'b0, 10'h030, 32'h0, 32'h5566BEEF, 1'b0);
        xfer(1'b0, 2'b01, 1'b1, 10'h032, 32'h0, 32'hFFFFBEEF, 1'b0);
        xfer(1'b0, 2'b01, 1'b0, 10'h032, 32'h0, 32'h0000BEEF, 1'b0);
        xfer(1'b0, 2'b01, 1'b1, 10'h030, 32'h0, 32'h00005566, 1'b0);

        // Misaligned word store, size=11 and misaligned half load
        xfer(1'b1, 2'b10, 1'b0, 10'h040, 32'h99AABBCC, 32'd0, 1'b0);
        xfer(1'b1, 2'b10, 1'b0, 10'h041, 32'hCAFEBABE, 32'd0, TRAP);
        v40 = TRAP ? 32'h99AABBCC : 32'hCAFEBABE;
        xfer(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, v40, 1'b0);
        xfer(1'b0, 2'b11, 1'b0, 10'h040, 32'h0, TRAP ? 32'd0 : v40, TRAP);
        xfer(1'b0, 2'b01, 1'b0, 10'h043, 32'h0, TRAP ? 32'd0 : {16'd0, v40[15:0]}, TRAP);

        // Back-to-back with LAT=0: 4 stores then 4 loads, req held high
        sel = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 2'b10, 1'b0, 10'(10'h100 + 4 * i), b2b_st[i], 32'd0, 1'b0);
        end
        prev = acc_cyc;
        access(1'b0, 2'b10, 1'b0, 10'h100, 32'h0, 32'hF00DF00D, 1'b0);
        chk("b2b_gap0", 32'(acc_cyc - prev), 32'd2);
        prev = acc_cyc;
        access(1'b0, 2'b10, 1'b0, 10'h104, 32'h0, 32'h01234567, 1'b0);
        chk("b2b_gap1", 32'(acc_cyc - prev), 32'd2);
        prev = acc_cyc;
        access(1'b0, 2'b00, 1'b1, 10'h10F, 32'h0, 32'hFFFFFF80, 1'b0);
        chk("b2b_gap2", 32'(acc_cyc - prev), 32'd2);
        prev = acc_cyc;
        access(1'b0, 2'b01, 1'b0, 10'h108, 32'h0, 32'h000089AB, 1'b0);
        chk("b2b_gap3", 32'(acc_cyc - prev), 32'd2);
        drop_req();
        drain();

        // Reset during WAIT with LAT=3 discards the store
        sel = 2;
        @(negedge clk);
        xfer(1'b1, 2'b10, 1'b0, 10'h050, 32'hCAFEF00D, 32'd0, 1'b0);
        we = 1'b1; size = 2'b10; sext = 1'b0; addr = 10'h050; wdata = 32'hDEADBEEF; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("wait_ready_low", {31'd0, cur_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, cur_ready}, 32'd1);
        chk("abort_done", {31'd0, cur_done}, 32'd0);
        chk("abort_err", {31'd0, cur_err}, 32'd0);
        chk("abort_rdata", cur_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 2'b10, 1'b0, 10'h050, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/dm_banked.md
# dm_banked

Parametrised, handshaked data memory for the MIPS core's MEM stage. Successor to the single-cycle byte-array data memory. It stores data as four byte lanes (big-endian), supports byte, halfword and word loads and stores with sign or zero extension, and inserts a configurable number of wait states. It reports misaligned accesses instead of silently corrupting neighbouring bytes.

## Interface
- `ADDR_W`, default 10: byte-address width. Capacity is 2^ADDR_W bytes, 2^(ADDR_W-2) words per lane.
- `LAT`, default 1: wait states per access, 0..15.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 1: access request; sampled only when `ready`=1.
- `we` input 1: 1 = store, 0 = load.
- `size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `sext` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` input ADDR_W: byte address.
- `wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ready` output 1: able to accept a request this cycle.
- `done` output 1: single-cycle completion pulse.
- `rdata` output 32: load result; valid only while `done`=1, 0 otherwise.
- `err` output 1: valid with `done`; access rejected.

## Operation
- Byte lanes: the byte at address a lives in word a[ADDR_W-1:2]. Lane order is big-endian: a[1:0]=00 maps to bits [31:24], 11 maps to [7:0].
- Halfword at a covers bytes a and a+1; a is the high byte.
- FSM:
  - IDLE: `ready`=1. `req` latches `we`, `size`, `sext`, `addr`, `wdata`. Goes to WAIT if LAT>0, else ACCESS.
  - WAIT: down-counter loaded with LAT-1. Goes to ACCESS when the counter reaches 0.
  - ACCESS: one edge. Stores write only the enabled lanes; loads capture the addressed word. Goes to RESP.
  - RESP: `done`=1 for one cycle and `ready`=1. A `req` in RESP is accepted, giving back-to-back operation; otherwise go to IDLE.
- Load extension: byte/half take bit 7/15 as the sign when `sext`=1; otherwise upper bits are 0. A word load ignores `sext`.
- Store lane enables:
  - byte: the one lane selected by addr[1:0].
  - half: lanes {a, a+1}.
  - word: all four lanes.
- Inputs are latched at acceptance; changes to inputs during WAIT/ACCESS have no effect.
- Memory contents are not reset and power up undefined.
- Reset (async, any state): state goes to IDLE, counter to 0, `ready`=1, `done`=0, `rdata`=0, `err`=0. A store not yet at ACCESS is discarded. No partial-lane writes are allowed.

## Timing
- Request accepted at edge E0. ACCESS happens at edge E(LAT+1). `done` is high in the cycle after E(LAT+1).
- Total latency is request to `done` = LAT+2 cycles: LAT=0 gives 2 cycles, LAT=1 gives 3.
- `ready` is low from after E0 until the RESP cycle.
- Throughput with continuous `req`: one access per LAT+2 cycles, because RESP overlaps the next IDLE acceptance.
- A store is visible to a load accepted in or after its RESP cycle.
- `rdata`/`err` are registered: no combinational path from inputs to outputs.

## Configuration
- `DM_MISALIGN_TRAP_EN` defined:
  - These are errors: half with addr[0]=1; word with addr[1:0]≠00; `size`=11.
  - An error access performs no write, returns `rdata`=0, and sets `err`=1 with `done`. Latency is unchanged.
- Not defined:
  - `err` is tied to 0.
  - Address low bits are forced aligned: half uses addr[0]=0, word uses addr[1:0]=00.
  - `size`=11 is treated as word.

## Test plan
- Reset then LAT=1 word store: store 0x11223344 to addr 0x010, then load word from 0x010.
  - `done` comes 3 cycles after each accept.
  - `rdata`=0x11223344.
  - Byte 0x013 reads back 0x44 with zero extension.
- Byte load, signed and unsigned: store byte 0x80 to 0x021. Load byte 0x021 with `sext`=1 → 0xFFFFFF80; with `sext`=0 → 0x00000080. The other lanes of word 0x020 are unchanged.
- Halfword: store 0xBEEF (wdata 0x1234BEEF) to 0x032. Then:
  - Word load of 0x030 gives 0xXXXXBEEF, where the upper half keeps its prior value.
  - Signed half load gives 0xFFFFBEEF.
- Misaligned access with `DM_MISALIGN_TRAP_EN`: word store to 0x041. The response is `err`=1 and `rdata`=0. A later word load of 0x040 shows the memory unchanged.
  - Without the macro, the same store writes word 0x040.
- Back-to-back, LAT=0: hold `req` high for 4 loads. Accepts occur every 2 cycles, and `done` pulses every 2 cycles with the correct data.
- Reset mid-store: LAT=3. Store 0xDEADBEEF to 0x050, assert `rst_n`=0 during WAIT. Outputs immediately read `ready`=1, `done`=0, `err`=0. A later load of 0x050 returns the value from before the aborted store.
